// File: rtl/lsu_byte_serial.sv
// lsu_byte_serial
// Load/store unit that turns one CPU load or store into 1, 2 or 4 single-byte
// memory cycles, lowest address (least significant byte) first. For loads it
// rebuilds the word and applies sign or zero extension. Requests that are
// illegal or out of range are answered with a fault and never reach memory.
//
// Handshake: a request transfers on a rising edge where req_valid_i and
// req_ready_o are both high. req_ready_o is high only in IDLE, so the unit
// holds one request at a time. resp_valid_o is a single-cycle pulse with no
// back-pressure; resp_fault_o and resp_rdata_o qualify that pulse.
//
// Ports
//   clk_i, rst_i       clock, asynchronous active-high reset
//   req_valid_i/req_ready_o/req_write_i/req_addr_i/req_func3_i/req_wdata_i
//                      request from the execute/memory stage (RV32 func3)
//   resp_valid_o/resp_rdata_o/resp_fault_o
//                      completion pulse with extended load data or fault
//   mem_addr_o/mem_re_o/mem_we_o/mem_wdata_o/mem_rdata_i
//                      byte-wide data memory port; read data is combinational
//   dbg_state_o        current FSM state (IDLE=0, ACCESS=1, DONE=2, FAULT=3)
module lsu_byte_serial #(
  parameter int DEPTH  = 64,
  parameter int ADDR_W = 8
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic              req_write_i,
  input  logic [31:0]       req_addr_i,
  input  logic [2:0]        req_func3_i,
  input  logic [31:0]       req_wdata_i,
  output logic              resp_valid_o,
  output logic [31:0]       resp_rdata_o,
  output logic              resp_fault_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic              mem_re_o,
  output logic              mem_we_o,
  output logic [7:0]        mem_wdata_o,
  input  logic [7:0]        mem_rdata_i,
  output logic [1:0]        dbg_state_o
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2,
    FAULT  = 2'd3
  } state_e;

  state_e            state_q, state_d;
  logic [1:0]        k_q, k_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [31:0]       buf_q, buf_d;
  logic              write_q;
  logic [2:0]        func3_q;
  logic [31:0]       wdata_q;

  logic              accept;
  logic              req_illegal;
  logic              req_oor;
  logic [32:0]       req_size;
  logic [1:0]        last_k;

  // Index of the final byte for the latched access size.
  always_comb begin
    case (func3_q[1:0])
      2'b00:   last_k = 2'd0;
      2'b01:   last_k = 2'd1;
      default: last_k = 2'd3;
    endcase
  end

  // Legality of the incoming request; only consulted in IDLE, and only
  // steers the next state, never the memory strobes directly.
  always_comb begin
    case (req_func3_i[1:0])
      2'b00:   req_size = 33'd1;
      2'b01:   req_size = 33'd2;
      default: req_size = 33'd4;
    endcase
    req_illegal = (req_func3_i[1:0] == 2'b11) ||
                  (req_write_i && req_func3_i[2]) ||
                  (!req_write_i && (req_func3_i == 3'b110));
    // 33-bit sum so an address near 2^32 cannot wrap back into range.
    req_oor = (|req_addr_i[31:ADDR_W]) ||
              (({1'b0, req_addr_i} + req_size) > 33'(DEPTH));
  end

  assign accept = (state_q == IDLE) && req_valid_i;

  always_comb begin
    state_d    = state_q;
    k_d        = k_q;
    mem_addr_d = mem_addr_q;
    buf_d      = buf_q;

    req_ready_o  = 1'b0;
    resp_valid_o = 1'b0;
    resp_fault_o = 1'b0;
    resp_rdata_o = 32'h0;
    mem_re_o     = 1'b0;
    mem_we_o     = 1'b0;
    mem_wdata_o  = 8'h00;

    case (state_q)
      IDLE: begin
        req_ready_o = 1'b1;
        if (req_valid_i) begin
          k_d   = 2'd0;
          buf_d = 32'h0;
          if (req_illegal || req_oor) begin
            // mem_addr keeps its previous value: a rejected request
            // never appears on the memory port.
            state_d = FAULT;
          end else begin
            state_d    = ACCESS;
            mem_addr_d = req_addr_i[ADDR_W-1:0];
          end
        end
      end
      ACCESS: begin
        if (write_q) begin
          mem_we_o    = 1'b1;
          mem_wdata_o = wdata_q[{k_q, 3'b000} +: 8];
        end else begin
          mem_re_o = 1'b1;
          buf_d[{k_q, 3'b000} +: 8] = mem_rdata_i;
        end
        // The address is not advanced past the last byte, so mem_addr
        // keeps showing the last byte accessed once the access ends.
        if (k_q == last_k) begin
          state_d = DONE;
        end else begin
          k_d        = k_q + 2'd1;
          mem_addr_d = mem_addr_q + ADDR_W'(1);
        end
      end
      DONE: begin
        resp_valid_o = 1'b1;
        if (!write_q) begin
          case (func3_q)
            3'b000:  resp_rdata_o = {{24{buf_q[7]}}, buf_q[7:0]};
            3'b001:  resp_rdata_o = {{16{buf_q[15]}}, buf_q[15:0]};
            3'b100:  resp_rdata_o = {24'h0, buf_q[7:0]};
            3'b101:  resp_rdata_o = {16'h0, buf_q[15:0]};
            default: resp_rdata_o = buf_q;
          endcase
        end
        state_d = IDLE;
      end
      FAULT: begin
        resp_valid_o = 1'b1;
        resp_fault_o = 1'b1;
        state_d      = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign mem_addr_o  = mem_addr_q;
  assign dbg_state_o = state_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      k_q        <= 2'd0;
      mem_addr_q <= '0;
      buf_q      <= 32'h0;
      write_q    <= 1'b0;
      func3_q    <= 3'b000;
      wdata_q    <= 32'h0;
    end else begin
      state_q    <= state_d;
      k_q        <= k_d;
      mem_addr_q <= mem_addr_d;
      buf_q      <= buf_d;
      if (accept) begin
        write_q <= req_write_i;
        func3_q <= req_func3_i;
        wdata_q <= req_wdata_i;
      end
    end
  end

endmodule

// File: tb/tb_lsu_byte_serial.sv
// tb_lsu_byte_serial
// Bench for lsu_byte_serial with a 64-byte behavioural memory. Each request
// pushes its expected response and expected memory cycles into queues; a
// monitor pops and compares them as the DUT produces them.
module tb_lsu_byte_serial;
  localparam int DEPTH  = 64;
  localparam int ADDR_W = 8;
  localparam int RESP_W = 41; // {fault, rdata[31:0], latency[7:0]}
  localparam int MEM_W  = 26; // {latency[7:0], re, we, addr[7:0], wdata[7:0]}

  logic              clk_i = 1'b0;
  logic              rst_i;
  logic              req_valid_i;
  logic              req_ready_o;
  logic              req_write_i;
  logic [31:0]       req_addr_i;
  logic [2:0]        req_func3_i;
  logic [31:0]       req_wdata_i;
  logic              resp_valid_o;
  logic [31:0]       resp_rdata_o;
  logic              resp_fault_o;
  logic [ADDR_W-1:0] mem_addr_o;
  logic              mem_re_o;
  logic              mem_we_o;
  logic [7:0]        mem_wdata_o;
  logic [7:0]        mem_rdata_i;
  logic [1:0]        dbg_state_o;

  logic [7:0] mem     [DEPTH];
  logic [7:0] ref_mem [DEPTH];

  logic [RESP_W-1:0] exp_q[$];
  logic [MEM_W-1:0]  mem_q[$];

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  int acc_cyc = 0;
  int resp_cnt = 0;

  lsu_byte_serial #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .req_valid_i  (req_valid_i),
    .req_ready_o  (req_ready_o),
    .req_write_i  (req_write_i),
    .req_addr_i   (req_addr_i),
    .req_func3_i  (req_func3_i),
    .req_wdata_i  (req_wdata_i),
    .resp_valid_o (resp_valid_o),
    .resp_rdata_o (resp_rdata_o),
    .resp_fault_o (resp_fault_o),
    .mem_addr_o   (mem_addr_o),
    .mem_re_o     (mem_re_o),
    .mem_we_o     (mem_we_o),
    .mem_wdata_o  (mem_wdata_o),
    .mem_rdata_i  (mem_rdata_i),
    .dbg_state_o  (dbg_state_o)
  );

  // ---------------- clock / memory / cycle counter ----------------
  always #5 clk_i = ~clk_i;

  always @(posedge clk_i) cyc <= cyc + 1;

  assign mem_rdata_i = (int'(mem_addr_o) < DEPTH) ? mem[mem_addr_o[5:0]] : 8'h00;

  always @(posedge clk_i) begin
    if (mem_we_o && (int'(mem_addr_o) < DEPTH)) mem[mem_addr_o[5:0]] <= mem_wdata_o;
  end

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  function automatic int size_of(input logic [2:0] f);
    return (f[1:0] == 2'b00) ? 1 : (f[1:0] == 2'b01) ? 2 : 4;
  endfunction

  function automatic logic [31:0] load_exp(input logic [31:0] a, input logic [2:0] f);
    logic [31:0] raw;
    raw = 32'h0;
    for (int k = 0; k < size_of(f); k++) raw[8*k +: 8] = ref_mem[(int'(a[7:0]) + k) % DEPTH];
    case (f)
      3'b000:  return {{24{raw[7]}}, raw[7:0]};
      3'b001:  return {{16{raw[15]}}, raw[15:0]};
      3'b100:  return {24'h0, raw[7:0]};
      3'b101:  return {16'h0, raw[15:0]};
      default: return raw;
    endcase
  endfunction

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk_i) begin
    logic [RESP_W-1:0] e;
    logic [MEM_W-1:0]  m;
    if (!rst_i) begin
      if (resp_valid_o) begin
        if (exp_q.size() == 0) begin
          check("resp_unexpected", 64'(resp_valid_o), 64'd0);
        end else begin
          e = exp_q.pop_front();
          check("resp_fault", 64'(resp_fault_o), 64'(e[40]));
          check("resp_rdata", 64'(resp_rdata_o), 64'(e[39:8]));
          check("resp_latency", 64'(cyc - acc_cyc), 64'(e[7:0]));
        end
        resp_cnt++;
      end else begin
        check("resp_idle_zero", {31'h0, resp_fault_o, resp_rdata_o}, 64'h0);
      end
      if (mem_re_o || mem_we_o) begin
        if (mem_q.size() == 0) begin
          check("mem_unexpected", {62'h0, mem_re_o, mem_we_o}, 64'h0);
        end else begin
          m = mem_q.pop_front();
          check("mem_cycle", 64'(cyc - acc_cyc), 64'(m[25:18]));
          check("mem_strobe", {62'h0, mem_re_o, mem_we_o}, 64'(m[17:16]));
          check("mem_addr", 64'(mem_addr_o), 64'(m[15:8]));
          check("mem_wdata", 64'(mem_wdata_o), 64'(m[7:0]));
        end
      end else begin
        check("mem_wdata_idle", 64'(mem_wdata_o), 64'h0);
      end
    end
  end

  // ---------------- driver ----------------
  task automatic wait_ready();
    int budget;
    budget = 0;
    while (!req_ready_o && budget < 20) begin
      @(negedge clk_i);
      budget++;
    end
    check("ready_before_req", 64'(req_ready_o), 64'd1);
  endtask

  task automatic present(input logic w, input logic [31:0] a, input logic [2:0] f,
                         input logic [31:0] wd);
    @(negedge clk_i);
    req_valid_i = 1'b1;
    req_write_i = w;
    req_addr_i  = a;
    req_func3_i = f;
    req_wdata_i = wd;
    @(posedge clk_i);
    #1;
    acc_cyc     = cyc;
    req_valid_i = 1'b0;
    // Scramble the request bus: the unit must use its latched copy.
    req_write_i = 1'($urandom_range(0, 1));
    req_addr_i  = $urandom;
    req_func3_i = 3'($urandom_range(0, 7));
    req_wdata_i = $urandom;
    check("ready_busy", 64'(req_ready_o), 64'd0);
  endtask

  task automatic do_req(input logic w, input logic [31:0] a, input logic [2:0] f,
                        input logic [31:0] wd);
    int  sz;
    int  target;
    int  budget;
    logic bad;
    sz  = size_of(f);
    bad = (f[1:0] == 2'b11) || (w && f[2]) || (!w && f == 3'b110) ||
          (a[31:8] != 24'h0) || (({1'b0, a} + 33'(sz)) > 33'(DEPTH));
    wait_ready();
    if (bad) begin
      exp_q.push_back({1'b1, 32'h0, 8'd0});
    end else begin
      for (int k = 0; k < sz; k++) begin
        mem_q.push_back({8'(k), !w, w, 8'(a[7:0] + 8'(k)), (w ? wd[8*k +: 8] : 8'h00)});
        if (w) ref_mem[int'(a[7:0]) + k] = wd[8*k +: 8];
      end
      exp_q.push_back({1'b0, (w ? 32'h0 : load_exp(a, f)), 8'(sz)});
    end
    target = resp_cnt + 1;
    present(w, a, f, wd);
    budget = 0;
    while (resp_cnt < target && budget < 20) begin
      @(posedge clk_i);
      #2;
      budget++;
    end
    if (resp_cnt < target) check("resp_timeout", 64'd0, 64'd1);
    check("ready_after_resp", 64'(req_ready_o), 64'd1);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    for (int i = 0; i < DEPTH; i++) begin
      mem[i]     = 8'(i * 7 + 3);
      ref_mem[i] = 8'(i * 7 + 3);
    end
    mem[0] = 8'h11; mem[1] = 8'h00; mem[2] = 8'h00; mem[3] = 8'h00;
    ref_mem[0] = 8'h11; ref_mem[1] = 8'h00; ref_mem[2] = 8'h00; ref_mem[3] = 8'h00;

    rst_i       = 1'b1;
    req_valid_i = 1'b0;
    req_write_i = 1'b0;
    req_addr_i  = 32'h0;
    req_func3_i = 3'b000;
    req_wdata_i = 32'h0;
    repeat (2) @(posedge clk_i);
    #1;
    check("rst_ready", 64'(req_ready_o), 64'd1);
    check("rst_state", 64'(dbg_state_o), 64'd0);
    check("rst_outputs", {resp_valid_o, resp_fault_o, resp_rdata_o, mem_addr_o,
                          mem_re_o, mem_we_o, mem_wdata_o}, 64'h0);
    @(negedge clk_i);
    rst_i = 1'b0;

    // Directed cases
    do_req(1'b0, 32'd0,  3'b010, 32'h0);          // LW 0 -> 0x11
    do_req(1'b1, 32'd5,  3'b000, 32'h00000080);   // SB 0x80 @5
    do_req(1'b0, 32'd5,  3'b000, 32'h0);          // LB  -> FFFFFF80
    do_req(1'b0, 32'd5,  3'b100, 32'h0);          // LBU -> 00000080
    do_req(1'b1, 32'd10, 3'b001, 32'h1234ABCD);   // SH
    do_req(1'b0, 32'd10, 3'b001, 32'h0);          // LH  -> FFFFABCD
    do_req(1'b0, 32'd10, 3'b101, 32'h0);          // LHU -> 0000ABCD
    do_req(1'b1, 32'd1,  3'b010, 32'hDEADBEEF);   // misaligned SW
    do_req(1'b0, 32'd1,  3'b010, 32'h0);          // LW -> DEADBEEF
    check("mem_byte1", 64'(mem[1]), 64'hEF);
    check("mem_byte2", 64'(mem[2]), 64'hBE);
    check("mem_byte3", 64'(mem[3]), 64'hAD);
    check("mem_byte4", 64'(mem[4]), 64'hDE);

    // Boundaries and faults
    do_req(1'b0, 32'd60,  3'b010, 32'h0);         // last legal word
    do_req(1'b0, 32'd62,  3'b010, 32'h0);         // fault: runs past end
    do_req(1'b0, 32'd63,  3'b001, 32'h0);         // fault
    do_req(1'b0, 32'd63,  3'b000, 32'h0);         // legal last byte
    do_req(1'b1, 32'h100, 3'b000, 32'h5A);        // fault: high bits
    do_req(1'b0, 32'd0,   3'b011, 32'h0);         // fault: func3 011
    do_req(1'b1, 32'd8,   3'b100, 32'h77);        // fault: store func3[2]
    do_req(1'b0, 32'd8,   3'b110, 32'h0);         // fault: load 110
    do_req(1'b0, 32'hFFFFFFFE, 3'b010, 32'h0);    // fault: no wrap

    // Random mix
    for (int i = 0; i < 40; i++) begin
      logic [31:0] a;
      a = 32'($urandom_range(0, 70));
      if ($urandom_range(0, 9) == 0) a[20] = 1'b1;
      do_req(1'($urandom_range(0, 1)), a, 3'($urandom_range(0, 7)), $urandom);
    end

    // Reset in the middle of a word store to address 20
    wait_ready();
    for (int k = 0; k < 2; k++) begin
      mem_q.push_back({8'(k), 1'b0, 1'b1, 8'(20 + k), 8'(32'hCAFEF00D >> (8 * k))});
    end
    ref_mem[20] = 8'h0D;
    ref_mem[21] = 8'hF0;
    present(1'b1, 32'd20, 3'b010, 32'hCAFEF00D);  // byte 0 in this cycle
    @(posedge clk_i);                             // byte 1
    @(posedge clk_i);                             // byte 2 starts
    #2;
    rst_i = 1'b1;
    #1;
    check("midrst_ready", 64'(req_ready_o), 64'd1);
    check("midrst_outputs", {resp_valid_o, resp_fault_o, resp_rdata_o, mem_addr_o,
                             mem_re_o, mem_we_o, mem_wdata_o}, 64'h0);
    @(negedge clk_i);
    @(negedge clk_i);
    rst_i = 1'b0;
    check("midrst_b20", 64'(mem[20]), 64'h0D);
    check("midrst_b21", 64'(mem[21]), 64'hF0);
    check("midrst_b22", 64'(mem[22]), 64'(ref_mem[22]));
    check("midrst_b23", 64'(mem[23]), 64'(ref_mem[23]));
    check("midrst_memq", 64'(mem_q.size()), 64'd0);
    do_req(1'b0, 32'd20, 3'b010, 32'h0);

    repeat (4) @(posedge clk_i);
    #1;
    check("final_resp_q", 64'(exp_q.size()), 64'd0);
    check("final_mem_q", 64'(mem_q.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
